// File: rtl/adder_rr_arbiter.sv
// One shared WIDTH-bit ripple adder time-multiplexed between NREQ requesters by a round-robin arbiter.
// Optional per-requester carry chaining is enabled by defining ADDER_CARRY_CHAIN_EN.
module adder_rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
`ifdef ADDER_CARRY_CHAIN_EN
    input  logic [NREQ-1:0]         chain,
`endif
    input  logic [NREQ*WIDTH-1:0]   a_flat,
    input  logic [NREQ*WIDTH-1:0]   b_flat,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH:0]          res,
    output logic [IDW-1:0]          res_id,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH:0]    res_q, res_d;
    logic [IDW-1:0]    res_id_q, res_id_d;
    logic              res_valid_q, res_valid_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;

    logic              found_c;
    logic [IDW-1:0]    win_c;
    logic [IDW:0]      cand_c;
    logic [WIDTH-1:0]  win_a_c;
    logic [WIDTH-1:0]  win_b_c;
    logic              cin_c;
    logic              carry_c;
    logic [WIDTH:0]    sum_c;

`ifdef ADDER_CARRY_CHAIN_EN
    logic              cin_q, cin_d;
    logic [NREQ-1:0]   cy_q, cy_d;
    logic              win_cin_c;
    assign cin_c = cin_q;
`else
    assign cin_c = 1'b0;
`endif

    // Round-robin search starting at ptr, wrapping modulo NREQ
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        cand_c  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand_c = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand_c >= (IDW+1)'(NREQ)) begin
                cand_c = cand_c - (IDW+1)'(NREQ);
            end
            if (!found_c && req[cand_c[IDW-1:0]]) begin
                found_c = 1'b1;
                win_c   = cand_c[IDW-1:0];
            end
        end
    end

    // Winner operand select
    always_comb begin
        win_a_c = '0;
        win_b_c = '0;
`ifdef ADDER_CARRY_CHAIN_EN
        win_cin_c = 1'b0;
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_c == IDW'(i)) begin
                win_a_c = a_flat[i*WIDTH +: WIDTH];
                win_b_c = b_flat[i*WIDTH +: WIDTH];
`ifdef ADDER_CARRY_CHAIN_EN
                win_cin_c = chain[i] & cy_q[i];
`endif
            end
        end
    end

    // Ripple-carry adder; with cin tied low the LSB stage reduces to a half adder
    always_comb begin
        sum_c   = '0;
        carry_c = cin_c;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum_c[i] = a_q[i] ^ b_q[i] ^ carry_c;
            carry_c  = (a_q[i] & b_q[i]) | (carry_c & (a_q[i] ^ b_q[i]));
        end
        sum_c[WIDTH] = carry_c;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        res_d       = res_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
        a_d         = a_q;
        b_d         = b_q;
`ifdef ADDER_CARRY_CHAIN_EN
        cin_d       = cin_q;
        cy_d        = cy_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found_c) begin
                    a_d      = win_a_c;
                    b_d      = win_b_c;
                    gnt_d    = NREQ'(1) << win_c;
                    res_id_d = win_c;
                    state_d  = CALC;
`ifdef ADDER_CARRY_CHAIN_EN
                    cin_d    = win_cin_c;
`endif
                end
            end
            CALC: begin
                res_d       = sum_c;
                res_valid_d = 1'b1;
                gnt_d       = '0;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    ptr_d       = (res_id_q == IDW'(NREQ-1)) ? '0 : res_id_q + IDW'(1);
                    state_d     = IDLE;
`ifdef ADDER_CARRY_CHAIN_EN
                    cy_d[res_id_q] = res_q[WIDTH];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            res_q       <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
`ifdef ADDER_CARRY_CHAIN_EN
            cin_q       <= 1'b0;
            cy_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            res_q       <= res_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
`ifdef ADDER_CARRY_CHAIN_EN
            cin_q       <= cin_d;
            cy_q        <= cy_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign res       = res_q;
    assign res_id    = res_id_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Cycle-by-cycle vector bench for adder_rr_arbiter; chain rows run only when ADDER_CARRY_CHAIN_EN is defined.
module tb_adder_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  chain;
    logic [15:0] a_flat;
    logic [15:0] b_flat;
    logic [3:0]  gnt;
    logic [4:0]  res;
    logic [1:0]  res_id;
    logic        res_valid;
    logic        res_ready;
    logic        busy;

    always #5 clk = ~clk;

    adder_rr_arbiter #(.NREQ(4), .WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
`ifdef ADDER_CARRY_CHAIN_EN
        .chain     (chain),
`endif
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .gnt       (gnt),
        .res       (res),
        .res_id    (res_id),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
    );

    // Inputs applied before an edge, outputs expected just after it
    typedef struct {
        string       tag;
        logic        rst;
        logic [3:0]  req;
        logic [15:0] a;
        logic [15:0] b;
        logic        rdy;
        logic [3:0]  chain;
        logic [3:0]  gnt;
        logic [4:0]  res;
        logic [1:0]  id;
        logic        v;
        logic        bsy;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input string tag, input logic r, input logic [3:0] rq,
                       input logic [15:0] a, input logic [15:0] b, input logic rdy,
                       input logic [3:0] ch, input logic [3:0] g, input logic [4:0] rs,
                       input logic [1:0] id, input logic v, input logic bsy);
        vec_t t;
        t.tag = tag; t.rst = r; t.req = rq; t.a = a; t.b = b; t.rdy = rdy;
        t.chain = ch; t.gnt = g; t.res = rs; t.id = id; t.v = v; t.bsy = bsy;
        vecs.push_back(t);
    endtask

    task automatic chk(input string tag, input string what, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h, want %0h", tag, what, act, exp);
        end
    endtask

    initial begin
        int          order[5];
        logic [4:0]  rr_res[5];
        logic [4:0]  prev;
        logic [3:0]  g;

        rst = 1'b1; req = '0; chain = '0; a_flat = '0; b_flat = '0; res_ready = 1'b0;

        // Reset, then a single request from requester 0
        add("rst0", 1, 4'b0000, 16'h0000, 16'h0000, 1, 4'h0, 4'b0000, 5'h00, 0, 0, 0);
        add("rst1", 1, 4'b0000, 16'h0000, 16'h0000, 1, 4'h0, 4'b0000, 5'h00, 0, 0, 0);
        add("s_gnt", 0, 4'b0001, 16'h0009, 16'h0008, 1, 4'h0, 4'b0001, 5'h00, 0, 0, 1);
        add("s_res", 0, 4'b0000, 16'h0009, 16'h0008, 1, 4'h0, 4'b0000, 5'h11, 0, 1, 1);
        add("s_idl", 0, 4'b0000, 16'h0009, 16'h0008, 1, 4'h0, 4'b0000, 5'h11, 0, 0, 0);

        // Round robin with all requests held, operands i+1 and i+2
        add("rr_rst", 1, 4'b0000, 16'h4321, 16'h5432, 1, 4'h0, 4'b0000, 5'h00, 0, 0, 0);
        order  = '{0, 1, 2, 3, 0};
        rr_res = '{5'h03, 5'h05, 5'h07, 5'h09, 5'h03};
        prev   = 5'h00;
        for (int k = 0; k < 5; k++) begin
            g = 4'b0001 << order[k];
            add($sformatf("rr%0d_gnt", k), 0, 4'b1111, 16'h4321, 16'h5432, 1, 4'h0, g, prev, 2'(order[k]), 0, 1);
            add($sformatf("rr%0d_res", k), 0, 4'b1111, 16'h4321, 16'h5432, 1, 4'h0, 4'b0000, rr_res[k], 2'(order[k]), 1, 1);
            add($sformatf("rr%0d_idl", k), 0, 4'b1111, 16'h4321, 16'h5432, 1, 4'h0, 4'b0000, rr_res[k], 2'(order[k]), 0, 0);
            prev = rr_res[k];
        end

        // Back-pressure on requester 2; requester 1 waits, then withdraws
        add("bp_gnt", 0, 4'b0100, 16'h0F00, 16'h0F00, 0, 4'h0, 4'b0100, 5'h03, 2, 0, 1);
        add("bp_res", 0, 4'b0000, 16'h0F00, 16'h0F00, 0, 4'h0, 4'b0000, 5'h1E, 2, 1, 1);
        for (int k = 0; k < 5; k++)
            add($sformatf("bp_hold%0d", k), 0, 4'b0010, 16'h0F00, 16'h0F00, 0, 4'h0, 4'b0000, 5'h1E, 2, 1, 1);
        add("bp_acc", 0, 4'b0010, 16'h0F00, 16'h0F00, 1, 4'h0, 4'b0000, 5'h1E, 2, 0, 0);
        add("bp_wdr", 0, 4'b0000, 16'h0F00, 16'h0F00, 1, 4'h0, 4'b0000, 5'h1E, 2, 0, 0);

        // Wrap priority: serve 3, then 1001 -> 0 then 3; serve 0, then 1001 -> 3
        add("w_s3g", 0, 4'b1000, 16'h2001, 16'h5003, 1, 4'h0, 4'b1000, 5'h1E, 3, 0, 1);
        add("w_s3r", 0, 4'b0000, 16'h2001, 16'h5003, 1, 4'h0, 4'b0000, 5'h07, 3, 1, 1);
        add("w_s3i", 0, 4'b0000, 16'h2001, 16'h5003, 1, 4'h0, 4'b0000, 5'h07, 3, 0, 0);
        add("w_a0g", 0, 4'b1001, 16'h2001, 16'h5003, 1, 4'h0, 4'b0001, 5'h07, 0, 0, 1);
        add("w_a0r", 0, 4'b1000, 16'h2001, 16'h5003, 1, 4'h0, 4'b0000, 5'h04, 0, 1, 1);
        add("w_a0i", 0, 4'b1000, 16'h2001, 16'h5003, 1, 4'h0, 4'b0000, 5'h04, 0, 0, 0);
        add("w_a3g", 0, 4'b1000, 16'h2001, 16'h5003, 1, 4'h0, 4'b1000, 5'h04, 3, 0, 1);
        add("w_a3r", 0, 4'b0000, 16'h2001, 16'h5003, 1, 4'h0, 4'b0000, 5'h07, 3, 1, 1);
        add("w_a3i", 0, 4'b0000, 16'h2001, 16'h5003, 1, 4'h0, 4'b0000, 5'h07, 3, 0, 0);
        add("w_s0g", 0, 4'b0001, 16'h2001, 16'h5003, 1, 4'h0, 4'b0001, 5'h07, 0, 0, 1);
        add("w_s0r", 0, 4'b0000, 16'h2001, 16'h5003, 1, 4'h0, 4'b0000, 5'h04, 0, 1, 1);
        add("w_s0i", 0, 4'b0000, 16'h2001, 16'h5003, 1, 4'h0, 4'b0000, 5'h04, 0, 0, 0);
        add("w_b3g", 0, 4'b1001, 16'h2001, 16'h5003, 1, 4'h0, 4'b1000, 5'h04, 3, 0, 1);
        add("w_b3r", 0, 4'b0001, 16'h2001, 16'h5003, 1, 4'h0, 4'b0000, 5'h07, 3, 1, 1);
        add("w_b3i", 0, 4'b0001, 16'h2001, 16'h5003, 1, 4'h0, 4'b0000, 5'h07, 3, 0, 0);
        add("w_b0g", 0, 4'b0001, 16'h2001, 16'h5003, 1, 4'h0, 4'b0001, 5'h07, 0, 0, 1);
        add("w_b0r", 0, 4'b0000, 16'h2001, 16'h5003, 1, 4'h0, 4'b0000, 5'h04, 0, 1, 1);
        add("w_b0i", 0, 4'b0000, 16'h2001, 16'h5003, 1, 4'h0, 4'b0000, 5'h04, 0, 0, 0);

        // Reset during CALC discards the op and rewinds ptr to 0
        add("r_gnt", 0, 4'b0010, 16'h0030, 16'h0040, 1, 4'h0, 4'b0010, 5'h04, 1, 0, 1);
        add("r_rst", 1, 4'b0010, 16'h0030, 16'h0040, 1, 4'h0, 4'b0000, 5'h00, 0, 0, 0);
        add("r_g0",  0, 4'b0011, 16'h0031, 16'h0042, 1, 4'h0, 4'b0001, 5'h00, 0, 0, 1);
        add("r_r0",  0, 4'b0010, 16'h0031, 16'h0042, 1, 4'h0, 4'b0000, 5'h03, 0, 1, 1);
        add("r_i0",  0, 4'b0010, 16'h0031, 16'h0042, 1, 4'h0, 4'b0000, 5'h03, 0, 0, 0);
        add("r_g1",  0, 4'b0010, 16'h0031, 16'h0042, 1, 4'h0, 4'b0010, 5'h03, 1, 0, 1);
        add("r_r1",  0, 4'b0000, 16'h0031, 16'h0042, 1, 4'h0, 4'b0000, 5'h07, 1, 1, 1);
        add("r_i1",  0, 4'b0000, 16'h0031, 16'h0042, 1, 4'h0, 4'b0000, 5'h07, 1, 0, 0);

`ifdef ADDER_CARRY_CHAIN_EN
        // Requester 1 chains F+1 into a following 0+0
        add("c1_gnt", 0, 4'b0010, 16'h00F0, 16'h0010, 1, 4'h0, 4'b0010, 5'h07, 1, 0, 1);
        add("c1_res", 0, 4'b0000, 16'h00F0, 16'h0010, 1, 4'h0, 4'b0000, 5'h10, 1, 1, 1);
        add("c1_idl", 0, 4'b0000, 16'h00F0, 16'h0010, 1, 4'h0, 4'b0000, 5'h10, 1, 0, 0);
        add("c2_gnt", 0, 4'b0010, 16'h0000, 16'h0000, 1, 4'h2, 4'b0010, 5'h10, 1, 0, 1);
        add("c2_res", 0, 4'b0000, 16'h0000, 16'h0000, 1, 4'h2, 4'b0000, 5'h01, 1, 1, 1);
        add("c2_idl", 0, 4'b0000, 16'h0000, 16'h0000, 1, 4'h2, 4'b0000, 5'h01, 1, 0, 0);
        add("c3_gnt", 0, 4'b0010, 16'h0000, 16'h0000, 1, 4'h0, 4'b0010, 5'h01, 1, 0, 1);
        add("c3_res", 0, 4'b0000, 16'h0000, 16'h0000, 1, 4'h0, 4'b0000, 5'h00, 1, 1, 1);
        add("c3_idl", 0, 4'b0000, 16'h0000, 16'h0000, 1, 4'h0, 4'b0000, 5'h00, 1, 0, 0);
`endif

        foreach (vecs[i]) begin
            rst       = vecs[i].rst;
            req       = vecs[i].req;
            a_flat    = vecs[i].a;
            b_flat    = vecs[i].b;
            res_ready = vecs[i].rdy;
            chain     = vecs[i].chain;
            @(posedge clk);
            #1;
            chk(vecs[i].tag, "gnt",       8'(gnt),       8'(vecs[i].gnt));
            chk(vecs[i].tag, "res",       8'(res),       8'(vecs[i].res));
            chk(vecs[i].tag, "res_id",    8'(res_id),    8'(vecs[i].id));
            chk(vecs[i].tag, "res_valid", 8'(res_valid), 8'(vecs[i].v));
            chk(vecs[i].tag, "busy",      8'(busy),      8'(vecs[i].bsy));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
